pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, width of every address port.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: cpu_req  in  1  CPU instruction-fetch request, sampled only when cpu_stall=0.
REQ-005 Port: cpu_addr  in  ADDR_W  CPU word fetch address.
REQ-006 Port: cpu_stall  out  1  CPU shall not present new requests while high.
REQ-007 Port: cpu_valid  out  1  one-cycle pulse; cpu_data holds the fetch result.
REQ-008 Port: cpu_data  out  16  fetched instruction word.
REQ-009 Port: prg_mode  in  1  programmer requests memory ownership (level).
REQ-010 Port: prg_addr  in  ADDR_W  programmer word address.
REQ-011 Port: prg_wdata  in  16  programmer write data (byte duplicated in both halves).
REQ-012 Port: prg_low  in  1  one-cycle strobe, write low byte.
REQ-013 Port: prg_high  in  1  one-cycle strobe, write high byte.
REQ-014 Port: prg_rdata  out  16  read-back word for programmer.
REQ-015 Port: mem_addr  out  ADDR_W  RAM address, registered.
REQ-016 Port: mem_wdata  out  16  RAM write data, registered.
REQ-017 Port: mem_we_lo / mem_we_hi  out  1 each  RAM byte write enables, registered.
REQ-018 Port: mem_rdata  in  16  RAM read data, valid one cycle after mem_addr.
REQ-019 Port (PMEM_WRCNT_EN only): wr_count  out  16  programmer write-strobe count.

Function
REQ-020 FSM states SHALL be CPU, DRAIN, PROG, RELEASE; reset state CPU.
REQ-021 CPU: prg_mode=1 -> DRAIN; else stay.
REQ-022 DRAIN: one cycle only, unconditionally -> PROG (covers the in-flight fetch).
REQ-023 PROG: prg_mode=0 -> RELEASE; else stay.
REQ-024 RELEASE: one cycle only, unconditionally -> CPU.
REQ-025 cpu_stall SHALL be 1 whenever next-state or current state is not CPU (i.e. asserted combinationally in the cycle prg_mode rises in CPU).
REQ-026 Fetch: cpu_req=1, cpu_stall=0 at cycle N -> mem_addr=cpu_addr, we=0 at N+1 -> cpu_valid=1, cpu_data=mem_rdata at N+2; one fetch per cycle, fully pipelined.
REQ-027 cpu_req while cpu_stall=1 SHALL be ignored (not queued).
REQ-028 A fetch accepted in the last CPU cycle SHALL still return cpu_valid (during DRAIN/PROG entry); cpu_data holds its value otherwise.
REQ-029 PROG write: prg_low|prg_high at cycle N -> at N+1 mem_addr=prg_addr, mem_wdata=prg_wdata, mem_we_lo=prg_low, mem_we_hi=prg_high; both strobes together -> both enables.
REQ-030 PROG, no strobe: mem_addr=prg_addr, enables 0; prg_rdata=mem_rdata each cycle (valid two cycles after prg_addr stable).
REQ-031 prg_rdata SHALL hold last value outside PROG.
REQ-032 prg_low/prg_high outside PROG SHALL be ignored: no write enable, no count.
REQ-033 Enables SHALL be 0 in every cycle not caused by REQ-029; never both CPU and programmer in one cycle.
REQ-034 Address/counter arithmetic wraps modulo width except where saturation is stated.

Reset
REQ-035 rst_n=0 SHALL asynchronously force: state CPU, cpu_stall 0, cpu_valid 0, cpu_data 0, prg_rdata 0, mem_addr 0, mem_wdata 0, mem_we_lo/hi 0, wr_count 0, pipeline valid flags 0.
REQ-036 Reset mid-write SHALL drop enables immediately; in-flight fetch SHALL not produce cpu_valid after release.

Configuration
REQ-037 Macro PMEM_WRCNT_EN defined: wr_count increments once per accepted strobe cycle (REQ-029), saturates at 16'hFFFF, clears to 0 on CPU->DRAIN transition.
REQ-038 Macro PMEM_WRCNT_EN undefined: wr_count port and counter logic absent; all other behaviour identical.

Verification
REQ-039 Fetch stream: cpu_req at cycles 1..4, addr 0x10..0x13, RAM word = ~addr -> cpu_valid cycles 3..6, cpu_data 0xFFEF..0xFFEC.
REQ-040 Takeover: fetch addr 0x20 accepted at cycle 5, prg_mode rises cycle 5 -> cpu_stall=1 cycle 5, cpu_valid with word 0x20 at cycle 7, state PROG at cycle 7.
REQ-041 Byte writes: PROG, prg_addr 0x0040, prg_wdata 0xA5A5, prg_low cycle N then prg_high cycle N+1 -> we_lo at N+1, we_hi at N+2, RAM[0x40]=0xA5A5, wr_count=2.
REQ-042 Ignored strobe: prg_mode=0, prg_low pulse -> no enable, RAM unchanged, wr_count unchanged.
REQ-043 Release: prg_mode falls -> RELEASE one cycle, cpu_stall=0 two cycles after fall, next fetch returns correct data.
REQ-044 Async reset: rst_n low mid-cycle during a write -> mem_we_lo/hi 0 immediately, all outputs at REQ-035 values before next clock edge.

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: arbitrates a single-port program RAM between a pipelined
// CPU instruction-fetch port and an external programmer.
//
// Ownership moves through CPU -> DRAIN -> PROG -> RELEASE -> CPU. The DRAIN
// cycle lets a fetch accepted in the last CPU cycle finish on the RAM bus
// before the programmer drives it. The RELEASE cycle keeps the CPU stalled
// for one extra cycle after the programmer lets go.
//
// RAM address, write data and byte enables are registered. Read data
// returns one cycle after the address. cpu_data and prg_rdata pass
// mem_rdata straight through while it is meaningful to that side, and
// otherwise show the last value that side saw.
//
// Optional feature: define PMEM_WRCNT_EN to add the wr_count output. It
// counts programmer write-strobe cycles, saturates at 16'hFFFF and clears
// whenever the programmer takes the memory.

module pmem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU fetch port
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_stall,
    output logic              cpu_valid,
    output logic [15:0]       cpu_data,
    // programmer port
    input  logic              prg_mode,
    input  logic [ADDR_W-1:0] prg_addr,
    input  logic [15:0]       prg_wdata,
    input  logic              prg_low,
    input  logic              prg_high,
    output logic [15:0]       prg_rdata,
    // RAM port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we_lo,
    output logic              mem_we_hi,
    input  logic [15:0]       mem_rdata
`ifdef PMEM_WRCNT_EN
    ,
    output logic [15:0]       wr_count
`endif
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_PROG    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    // decoded controls
    logic               fetch_accept;   // CPU fetch taken this cycle
    logic               prog_active;    // programmer owns the RAM bus
    logic               prog_write;     // programmer byte strobe taken

    // fetch pipeline: address on the RAM bus, then data back
    logic               fetch_pend_reg;
    logic               cpu_valid_reg;
    logic [15:0]        cpu_hold_reg;
    logic [15:0]        prg_hold_reg;

    // registered RAM bus
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [15:0]        mem_wdata_reg;
    logic               mem_we_lo_reg;
    logic               mem_we_hi_reg;

    // State register: ownership FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_CPU;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: DRAIN and RELEASE each last exactly one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CPU:     if (prg_mode)  state_next = ST_DRAIN;
            ST_DRAIN:                  state_next = ST_PROG;
            ST_PROG:    if (!prg_mode) state_next = ST_RELEASE;
            ST_RELEASE:                state_next = ST_CPU;
            default:                   state_next = ST_CPU;
        endcase
    end

    // Output decode. A fetch presented in the cycle prg_mode rises is still
    // taken, because DRAIN lets it finish. The stall warns the CPU off any
    // further requests from that cycle on.
    always_comb begin
        fetch_accept = 1'b0;
        prog_active  = 1'b0;
        prog_write   = 1'b0;
        case (state_reg)
            ST_CPU:  fetch_accept = cpu_req;
            ST_PROG: begin
                prog_active = 1'b1;
                prog_write  = prg_low | prg_high;
            end
            default: ;
        endcase
        cpu_stall = rst_n & ((state_reg != ST_CPU) | (state_next != ST_CPU));
    end

    // RAM bus registers. Enables are raised only by an accepted programmer
    // strobe, so CPU and programmer can never drive the bus in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_lo_reg <= 1'b0;
            mem_we_hi_reg <= 1'b0;
        end else begin
            mem_we_lo_reg <= prog_write & prg_low;
            mem_we_hi_reg <= prog_write & prg_high;
            if (fetch_accept) begin
                mem_addr_reg <= cpu_addr;
            end else if (prog_active) begin
                mem_addr_reg <= prg_addr;
            end
            if (prog_write) begin
                mem_wdata_reg <= prg_wdata;
            end
        end
    end

    // Fetch pipeline: address stage, then the data-return stage pulses cpu_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pend_reg <= 1'b0;
            cpu_valid_reg  <= 1'b0;
        end else begin
            fetch_pend_reg <= fetch_accept;
            cpu_valid_reg  <= fetch_pend_reg;
        end
    end

    // Keep the last word seen by each side so its output holds between returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold_reg <= '0;
            prg_hold_reg <= '0;
        end else begin
            if (cpu_valid_reg) begin
                cpu_hold_reg <= mem_rdata;
            end
            if (prog_active) begin
                prg_hold_reg <= mem_rdata;
            end
        end
    end

`ifdef PMEM_WRCNT_EN
    logic        take_over;
    logic [15:0] wr_count_reg;

    assign take_over = (state_reg == ST_CPU) && (state_next == ST_DRAIN);

    // Write-strobe counter: cleared at each takeover, saturating upward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_reg <= '0;
        end else if (take_over) begin
            wr_count_reg <= '0;
        end else if (prog_write && (wr_count_reg != 16'hFFFF)) begin
            wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    assign wr_count = wr_count_reg;
`endif

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_we_lo = mem_we_lo_reg;
    assign mem_we_hi = mem_we_hi_reg;
    assign cpu_valid = cpu_valid_reg;
    assign cpu_data  = cpu_valid_reg ? mem_rdata : cpu_hold_reg;
    assign prg_rdata = prog_active ? mem_rdata : prg_hold_reg;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed, table-driven bench for pmem_arbiter with a
// behavioural byte-writable RAM (registered read, preloaded with ~addr).
// Builds with or without PMEM_WRCNT_EN.

module tb_pmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_stall;
    logic        cpu_valid;
    logic [15:0] cpu_data;
    logic        prg_mode;
    logic [15:0] prg_addr;
    logic [15:0] prg_wdata;
    logic        prg_low;
    logic        prg_high;
    logic [15:0] prg_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we_lo;
    logic        mem_we_hi;
    logic [15:0] mem_rdata;
`ifdef PMEM_WRCNT_EN
    logic [15:0] wr_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_stall (cpu_stall),
        .cpu_valid (cpu_valid),
        .cpu_data  (cpu_data),
        .prg_mode  (prg_mode),
        .prg_addr  (prg_addr),
        .prg_wdata (prg_wdata),
        .prg_low   (prg_low),
        .prg_high  (prg_high),
        .prg_rdata (prg_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we_lo (mem_we_lo),
        .mem_we_hi (mem_we_hi),
        .mem_rdata (mem_rdata)
`ifdef PMEM_WRCNT_EN
        ,
        .wr_count  (wr_count)
`endif
    );

    // RAM model: preload ~addr while ram_init is high, then byte writes and
    // a registered read (old data on a same-edge write).
    logic [15:0] ram [0:255];
    logic        ram_init;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 256; k++) ram[k] <= ~(16'(k));
            mem_rdata <= 16'h0000;
        end else begin
            if (mem_we_lo) ram[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
            if (mem_we_hi) ram[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        mode;
        logic [15:0] paddr;
        logic [15:0] pwdata;
        logic        plo;
        logic        phi;
        logic        e_stall;
        logic        e_valid;
        logic        ck_data;
        logic [15:0] e_data;
        logic        e_lo;
        logic        e_hi;
        logic        ck_addr;
        logic [15:0] e_addr;
        logic        ck_prd;
        logic [15:0] e_prd;
        logic        ck_cnt;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mv(
        input logic rq, input logic [15:0] ad, input logic md,
        input logic [15:0] pa, input logic [15:0] pw, input logic lo, input logic hi,
        input logic st, input logic va, input logic ckd, input logic [15:0] d,
        input logic elo, input logic ehi, input logic cka, input logic [15:0] a,
        input logic ckp, input logic [15:0] p, input logic ckc, input logic [15:0] c);
        vec_t v;
        v.req = rq; v.addr = ad; v.mode = md; v.paddr = pa; v.pwdata = pw;
        v.plo = lo; v.phi = hi; v.e_stall = st; v.e_valid = va; v.ck_data = ckd;
        v.e_data = d; v.e_lo = elo; v.e_hi = ehi; v.ck_addr = cka; v.e_addr = a;
        v.ck_prd = ckp; v.e_prd = p; v.ck_cnt = ckc; v.e_cnt = c;
        return v;
    endfunction

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_addr = '0; prg_mode = 1'b0; prg_addr = '0;
        prg_wdata = '0; prg_low = 1'b0; prg_high = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " stall"},  {15'd0, cpu_stall}, 16'h0000);
        chk({tag, " valid"},  {15'd0, cpu_valid}, 16'h0000);
        chk({tag, " data"},   cpu_data,           16'h0000);
        chk({tag, " prdata"}, prg_rdata,          16'h0000);
        chk({tag, " maddr"},  mem_addr,           16'h0000);
        chk({tag, " wdata"},  mem_wdata,          16'h0000);
        chk({tag, " we"},     {14'd0, mem_we_hi, mem_we_lo}, 16'h0000);
`ifdef PMEM_WRCNT_EN
        chk({tag, " wrcnt"},  wr_count,           16'h0000);
`endif
    endtask

    initial begin
        //             req addr  md paddr  pwdata  lo hi | st va ckd data   lo hi cka addr   ckp prd    ckc cnt
        vecs[0]  = mv(0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 16'h0000, 1, 16'h0000, 1, 16'd0);
        vecs[1]  = mv(1, 16'h10, 0, 16'h00, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'd0);
        vecs[2]  = mv(1, 16'h11, 0, 16'h00, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0010, 0, 16'h0000, 0, 16'd0);
        vecs[3]  = mv(1, 16'h12, 0, 16'h00, 16'h0000, 0, 0, 0, 1, 1, 16'hFFEF, 0, 0, 1, 16'h0011, 0, 16'h0000, 0, 16'd0);
        vecs[4]  = mv(1, 16'h13, 0, 16'h00, 16'h0000, 0, 0, 0, 1, 1, 16'hFFEE, 0, 0, 1, 16'h0012, 0, 16'h0000, 0, 16'd0);
        vecs[5]  = mv(1, 16'h20, 1, 16'h00, 16'h0000, 0, 0, 1, 1, 1, 16'hFFED, 0, 0, 1, 16'h0013, 0, 16'h0000, 0, 16'd0);
        vecs[6]  = mv(0, 16'h00, 1, 16'h00, 16'h0000, 0, 0, 1, 1, 1, 16'hFFEC, 0, 0, 1, 16'h0020, 0, 16'h0000, 0, 16'd0);
        vecs[7]  = mv(0, 16'h00, 1, 16'h40, 16'h0000, 0, 0, 1, 1, 1, 16'hFFDF, 0, 0, 1, 16'h0020, 1, 16'hFFDF, 1, 16'd0);
        vecs[8]  = mv(0, 16'h00, 1, 16'h40, 16'hA5A5, 1, 0, 1, 0, 1, 16'hFFDF, 0, 0, 1, 16'h0040, 1, 16'hFFDF, 0, 16'd0);
        vecs[9]  = mv(0, 16'h00, 1, 16'h40, 16'hA5A5, 0, 1, 1, 0, 1, 16'hFFDF, 1, 0, 1, 16'h0040, 1, 16'hFFBF, 0, 16'd0);
        vecs[10] = mv(0, 16'h00, 1, 16'h40, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 1, 1, 16'h0040, 1, 16'hFFBF, 0, 16'd0);
        vecs[11] = mv(0, 16'h00, 1, 16'h40, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 16'h0040, 1, 16'hFFA5, 0, 16'd0);
        vecs[12] = mv(0, 16'h00, 0, 16'h40, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 16'h0040, 1, 16'hA5A5, 0, 16'd0);
        vecs[13] = mv(1, 16'h30, 0, 16'h40, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 16'h0040, 1, 16'hA5A5, 1, 16'd2);
        vecs[14] = mv(1, 16'h40, 0, 16'h41, 16'h5A5A, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0040, 1, 16'hA5A5, 0, 16'd0);
        vecs[15] = mv(1, 16'h41, 0, 16'h00, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0040, 0, 16'h0000, 0, 16'd0);
        vecs[16] = mv(0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 0, 1, 1, 16'hA5A5, 0, 0, 1, 16'h0041, 0, 16'h0000, 0, 16'd0);
        vecs[17] = mv(0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 0, 1, 1, 16'hFFBE, 0, 0, 1, 16'h0041, 0, 16'h0000, 0, 16'd0);
        vecs[18] = mv(0, 16'h00, 0, 16'h00, 16'h0000, 0, 0, 0, 0, 1, 16'hFFBE, 0, 0, 0, 16'h0000, 1, 16'hA5A5, 1, 16'd2);

        // ---- reset ----
        drive_idle();
        rst_n    = 1'b0;
        ram_init = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        $display("reset: stall=%b valid=%b data=%h maddr=%h", cpu_stall, cpu_valid, cpu_data, mem_addr);
        @(posedge clk); #1;
        ram_init = 1'b0;
        rst_n    = 1'b1;

        // ---- table: fetch stream, takeover, byte writes, ignored strobe, release ----
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            cpu_req   = vecs[i].req;
            cpu_addr  = vecs[i].addr;
            prg_mode  = vecs[i].mode;
            prg_addr  = vecs[i].paddr;
            prg_wdata = vecs[i].pwdata;
            prg_low   = vecs[i].plo;
            prg_high  = vecs[i].phi;
            @(negedge clk);
            chk($sformatf("v%0d stall", i), {15'd0, cpu_stall}, {15'd0, vecs[i].e_stall});
            chk($sformatf("v%0d valid", i), {15'd0, cpu_valid}, {15'd0, vecs[i].e_valid});
            chk($sformatf("v%0d we_lo", i), {15'd0, mem_we_lo}, {15'd0, vecs[i].e_lo});
            chk($sformatf("v%0d we_hi", i), {15'd0, mem_we_hi}, {15'd0, vecs[i].e_hi});
            if (vecs[i].ck_data) chk($sformatf("v%0d cpu_data", i), cpu_data, vecs[i].e_data);
            if (vecs[i].ck_addr) chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            if (vecs[i].ck_prd)  chk($sformatf("v%0d prg_rdata", i), prg_rdata, vecs[i].e_prd);
`ifdef PMEM_WRCNT_EN
            if (vecs[i].ck_cnt)  chk($sformatf("v%0d wr_count", i), wr_count, vecs[i].e_cnt);
`endif
            $display("vec %0d: stall=%b valid=%b data=%h maddr=%h we=%b%b prd=%h",
                     i, cpu_stall, cpu_valid, cpu_data, mem_addr, mem_we_hi, mem_we_lo, prg_rdata);
        end
        chk("ram[0x40] after byte writes", ram[8'h40], 16'hA5A5);
        chk("ram[0x41] after ignored strobe", ram[8'h41], 16'hFFBE);

        // ---- takeover clears the count, then asynchronous reset during a write ----
        @(posedge clk); #1;
        drive_idle();
        prg_mode = 1'b1;
        @(negedge clk);
        chk("seqB stall on rise", {15'd0, cpu_stall}, 16'h0001);
        @(posedge clk); #1;                      // DRAIN
        @(negedge clk);
`ifdef PMEM_WRCNT_EN
        chk("seqB wr_count cleared", wr_count, 16'h0000);
`endif
        @(posedge clk); #1;                      // PROG: high-byte strobe
        prg_addr  = 16'h0060;
        prg_wdata = 16'h1234;
        prg_high  = 1'b1;
        @(posedge clk); #1;
        prg_high  = 1'b0;
        @(negedge clk);
        chk("seqB we_hi before reset", {15'd0, mem_we_hi}, 16'h0001);
        chk("seqB mem_wdata", mem_wdata, 16'h1234);
        chk("seqB mem_addr", mem_addr, 16'h0060);
`ifdef PMEM_WRCNT_EN
        chk("seqB wr_count", wr_count, 16'h0001);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("seqB async reset");
        $display("seqB: reset during write, we=%b%b maddr=%h", mem_we_hi, mem_we_lo, mem_addr);
        prg_mode = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- in-flight fetch is discarded by reset ----
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0060;
        @(posedge clk); #1;
        cpu_req  = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("seqC no valid after reset %0d", k), {15'd0, cpu_valid}, 16'h0000);
            @(posedge clk); #1;
        end
        $display("seqC: in-flight fetch dropped, valid=%b", cpu_valid);

        // fetch 0x60 again: the high-byte write was cut off by reset
        cpu_req  = 1'b1;
        cpu_addr = 16'h0060;
        @(posedge clk); #1;
        cpu_req  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("seqC refetch valid", {15'd0, cpu_valid}, 16'h0001);
        chk("seqC refetch data", cpu_data, 16'hFF9F);
        $display("seqC: refetch 0x60 valid=%b data=%h", cpu_valid, cpu_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
